// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parameterised serial sequence detector.
package seq_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 16;

  localparam int unsigned DEFAULT_PAT_W   = 3;
  localparam logic [2:0]  DEFAULT_PATTERN = 3'b101;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= inc ? W'(1) : '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_detect_param.sv
// Moore serial pattern detector with KMP fallback, overlap control and match counter.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             ovl,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned SW     = clog2(PAT_W + 1);
  localparam logic [SW-1:0] S_FULL = SW'(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W out of range");
  end

  logic [SW-1:0]    r_state;
  logic [SW-1:0]    w_state_nxt;
  logic [PAT_W-2:0] r_hist;
  logic [PAT_W-2:0] w_hist_nxt;
  logic [PAT_W-1:0] w_shift;
  logic             w_inc;

  // Longest prefix (bounded by s+1) that is a suffix of history followed by b.
  function automatic logic [SW-1:0] f_next_state(input logic [SW-1:0]    s,
                                                 input logic             b,
                                                 input logic [PAT_W-2:0] h);
    logic [PAT_W-1:0] win;
    int unsigned      lim;
    logic             ok;
    logic [SW-1:0]    res;
    win = {h, b};
    lim = (32'(s) >= PAT_W) ? PAT_W : 32'(s) + 1;
    res = '0;
    for (int unsigned j = 1; j <= PAT_W; j++) begin
      ok = (j <= lim);
      for (int unsigned k = 0; k < PAT_W; k++) begin
        if (k < j) begin
          if (win[k] != PATTERN[PAT_W-j+k]) ok = 1'b0;
        end
      end
      if (ok) res = SW'(j);
    end
    return res;
  endfunction

  assign w_shift = {r_hist, din};

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    if (din_vld) begin
      // Non-overlapping mode restarts the search after a completed match.
      w_state_nxt = f_next_state(((r_state == S_FULL) && !ovl) ? '0 : r_state, din, r_hist);
      w_hist_nxt  = (w_state_nxt == '0) ? '0 : w_shift[PAT_W-2:0];
    end
  end

  assign w_inc = din_vld && (w_state_nxt == S_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= '0;
      r_hist  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
    end
  end

  assign y = (r_state == S_FULL);

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_inc),
    .clr(clr_cnt),
    .q  (match_cnt)
  );

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b101: target pattern, PAT_W bits; the MSB is the first bit received.
REQ-003 Parameter CNT_W, default 8: match counter width, legal range 1..16.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port din, input, 1: serial data bit.
REQ-007 Port din_vld, input, 1: din is sampled only on edges where din_vld=1.
REQ-008 Port ovl, input, 1: 1 = overlapping detection, 0 = non-overlapping detection; sampled with each valid bit.
REQ-009 Port clr_cnt, input, 1: synchronous clear of match_cnt.
REQ-010 Port y, output, 1: Moore match flag.
REQ-011 Port match_cnt, output, CNT_W: saturating count of detected matches.

Function
REQ-012 Moore FSM; state S = number of pattern prefix bits currently matched, range 0..PAT_W; encoding width is clog2(PAT_W+1).
REQ-013 y SHALL be 1 exactly while S==PAT_W, decoded from the state register only, with no combinational path from din.
REQ-014 On a valid bit b in state S<PAT_W, or in state S==PAT_W with ovl=1: next S is the largest j<=min(S+1,PAT_W) such that the last j received bits equal PATTERN's first j bits (KMP fallback).
REQ-015 On a valid bit b in state S==PAT_W with ovl=0: next S is evaluated as if the current state were 0.
REQ-016 The received-bit history used for fallback covers at most PAT_W-1 bits; it is held in a register and is cleared on every transition to S=0.
REQ-017 With din_vld=0: S, the history, and y hold, and match_cnt changes only via clr_cnt.
REQ-018 Latency: y rises on the first clock edge that samples the completing bit; it stays high for one valid-bit period; with din_vld low it stays high until the next valid bit.
REQ-019 match_cnt increments by 1 on each transition into S=PAT_W, including PAT_W->PAT_W in overlap mode; it saturates at 2^CNT_W-1 and does not wrap.
REQ-020 If clr_cnt and an increment fall on the same edge, match_cnt becomes 1; clr_cnt alone gives 0.
REQ-021 A change of ovl takes effect on the next valid bit; the current S is not altered.
REQ-022 Illegal parameters (PAT_W<2, PAT_W>16, CNT_W<1) SHALL be rejected at elaboration.

Reset
REQ-023 rst=0 SHALL immediately force S=0, history=0, y=0, and match_cnt=0, independent of clk.
REQ-024 Release of rst is synchronous to clk; the first bit sampled after release is evaluated from S=0.
REQ-025 Reset asserted mid-pattern SHALL discard partial matches; no match spanning the reset is reported.

Structure
REQ-026 A shared package seq_pkg holds the state-width function (clog2), the parameter range limits, and the default pattern constant.
REQ-027 The saturating counter is a sub-module sat_counter (parameter W; ports clk, rst, inc, clr, q).
REQ-028 The next-state/fallback logic is a combinational function inside seq_detect_param and is not a separate module.

Verification
REQ-029 Scenario: defaults, ovl=1, din_vld=1, stream 1,1,0,0,1,0,1,1,0 -> y high only after the 7th bit; match_cnt=1.
REQ-030 Scenario: defaults, stream 1,0,1,0,1 -> with ovl=1, y pulses after bits 3 and 5 and match_cnt=2; with ovl=0, y pulses after bit 3 only and match_cnt=1.
REQ-031 Scenario: PAT_W=4, PATTERN=4'b1101, ovl=1, stream 1,1,0,1,1,0,1 -> y after bits 4 and 7; match_cnt=2.
REQ-032 Scenario: defaults, stream 1,0 then din_vld=0 for 5 cycles (din toggling), then 1 -> S holds at 2; y after the resumed bit; match_cnt=1.
REQ-033 Scenario: CNT_W=2, ovl=1, stream 1,0 followed by ten repeats of 1,0 -> match_cnt saturates at 3; clr_cnt on the same edge as a match -> 1.
REQ-034 Scenario: defaults, stream 1,0, then rst low for 3 ns mid-cycle, then 1 -> y=0 and match_cnt=0 immediately on rst low; no match after the 1; a further 0,1 then gives a match.
